octant_restore: RTL

- Inverse of the angle-reduction stage on the Bresenham path.
- The ray tracer runs in the first octant (0 ≤ dy ≤ dx) and produces a stream of cell offsets.
- This block takes those offsets, undoes the octant reduction using the three flip flags (identity swap, then x flip, then y flip), adds the ray origin, and streams absolute map-cell coordinates to the map-update logic.
- It is a 2-stage valid/ready pipeline with per-ray configuration latching and a per-ray cell counter.

---
 rtl/bresenham_pkg.sv | 11 +
 rtl/octant_map.sv | 18 +
 rtl/octant_restore.sv | 136 +++++++++++++
 3 files changed

// File: rtl/bresenham_pkg.sv
// bresenham_pkg: types and constants shared along the Bresenham ray path.
package bresenham_pkg;
  localparam int PKG_COORD_W = 16;
  localparam logic [15:0] PI_FX = 16'h3244;
  typedef logic signed [PKG_COORD_W-1:0] coord_t;
  typedef struct packed {
    logic flip_y;
    logic flip_x;
    logic flip_identity;
  } octant_flags_t;
endpackage

// File: rtl/octant_map.sv
// octant_map: maps a first-octant offset back to its true octant (swap, then x flip, then y flip).
module octant_map import bresenham_pkg::*; #(
  parameter int W = 16
) (
  input  logic [W-1:0]  dx,
  input  logic [W-1:0]  dy,
  input  octant_flags_t flags,
  output logic [W-1:0]  x1,
  output logic [W-1:0]  y1
);
  logic [W-1:0] a, b;
  always_comb begin
    a = flags.flip_identity ? dy : dx;
    b = flags.flip_identity ? dx : dy;
    x1 = flags.flip_x ? -a : a;
    y1 = flags.flip_y ? -b : b;
  end
endmodule

// File: rtl/octant_restore.sv
// octant_restore: 2-stage pipeline turning first-octant offsets into absolute map cells.
// Define BOUNDS_CHECK_EN to drop off-map cells and expose oob_count.
module octant_restore import bresenham_pkg::*; #(
  parameter int COORD_W = 16,
  parameter int CNT_W   = 12,
  parameter int MAP_DIM = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [COORD_W-1:0] cfg_origin_x,
  input  logic [COORD_W-1:0] cfg_origin_y,
  input  logic               cfg_flip_y,
  input  logic               cfg_flip_x,
  input  logic               cfg_flip_identity,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] in_dx,
  input  logic [COORD_W-1:0] in_dy,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic               out_last,
  output logic               ray_done,
`ifdef BOUNDS_CHECK_EN
  output logic [CNT_W-1:0]   oob_count,
`endif
  output logic [CNT_W-1:0]   cell_count
);
`ifdef BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif
  localparam logic [COORD_W-1:0] MAP_LIM = COORD_W'(MAP_DIM);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  octant_flags_t flags_q, flags_d;
  logic [COORD_W-1:0] org_x_q, org_x_d, org_y_q, org_y_d;
  logic [COORD_W-1:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d, s1_ox_q, s1_ox_d, s1_oy_q, s1_oy_d;
  logic [COORD_W-1:0] s2_x_q, s2_x_d, s2_y_q, s2_y_d, map_x, map_y;
  logic s1_v_q, s1_v_d, s1_last_q, s1_last_d, s2_v_q, s2_v_d, s2_last_q, s2_last_d;
  logic ray_done_q, ray_done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic cfg_acc, in_xfer, in_map, s2_leave, s1_adv, out_xfer;

  octant_map #(.W(COORD_W)) u_map (
    .dx(in_dx), .dy(in_dy), .flags(flags_q), .x1(map_x), .y1(map_y)
  );

  // A stage-2 beat leaves either by handshake or, when off-map, by being dropped.
  assign in_map    = !s2_x_q[COORD_W-1] && !s2_y_q[COORD_W-1] && s2_x_q < MAP_LIM && s2_y_q < MAP_LIM;
  assign out_valid = s2_v_q && (in_map || !BOUNDS_EN);
  assign s2_leave  = s2_v_q && (out_ready || !out_valid);
  assign s1_adv    = s1_v_q && (!s2_v_q || s2_leave);
  assign out_xfer  = out_valid && out_ready;
  assign cfg_ready = state_q == IDLE;
  assign in_ready  = state_q == RUN && (!s1_v_q || s1_adv);
  assign cfg_acc   = cfg_valid && cfg_ready;
  assign in_xfer   = in_valid && in_ready;
  assign out_x      = s2_x_q;
  assign out_y      = s2_y_q;
  assign out_last   = s2_last_q;
  assign ray_done   = ray_done_q;
  assign cell_count = cnt_q;

  always_comb begin
    state_d = cfg_acc ? RUN : (in_xfer && in_last) ? IDLE : state_q;
    flags_d = cfg_acc ? {cfg_flip_y, cfg_flip_x, cfg_flip_identity} : flags_q;
    org_x_d = cfg_acc ? cfg_origin_x : org_x_q;
    org_y_d = cfg_acc ? cfg_origin_y : org_y_q;
    cnt_d = cfg_acc ? '0 : (out_xfer && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    s1_v_d    = in_xfer || (s1_v_q && !s1_adv);
    s1_x_d    = in_xfer ? map_x : s1_x_q;
    s1_y_d    = in_xfer ? map_y : s1_y_q;
    s1_ox_d   = in_xfer ? org_x_q : s1_ox_q;
    s1_oy_d   = in_xfer ? org_y_q : s1_oy_q;
    s1_last_d = in_xfer ? in_last : s1_last_q;
    s2_v_d    = s1_adv || (s2_v_q && !s2_leave);
    s2_x_d    = s1_adv ? s1_ox_q + s1_x_q : s2_x_q;
    s2_y_d    = s1_adv ? s1_oy_q + s1_y_q : s2_y_q;
    s2_last_d = s1_adv ? s1_last_q : s2_last_q;
    ray_done_d = s2_leave && s2_last_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      flags_q    <= '0;
      org_x_q    <= '0;
      org_y_q    <= '0;
      cnt_q      <= '0;
      s1_v_q     <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_ox_q    <= '0;
      s1_oy_q    <= '0;
      s1_last_q  <= 1'b0;
      s2_v_q     <= 1'b0;
      s2_x_q     <= '0;
      s2_y_q     <= '0;
      s2_last_q  <= 1'b0;
      ray_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      flags_q    <= flags_d;
      org_x_q    <= org_x_d;
      org_y_q    <= org_y_d;
      cnt_q      <= cnt_d;
      s1_v_q     <= s1_v_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s1_ox_q    <= s1_ox_d;
      s1_oy_q    <= s1_oy_d;
      s1_last_q  <= s1_last_d;
      s2_v_q     <= s2_v_d;
      s2_x_q     <= s2_x_d;
      s2_y_q     <= s2_y_d;
      s2_last_q  <= s2_last_d;
      ray_done_q <= ray_done_d;
    end
  end

`ifdef BOUNDS_CHECK_EN
  logic [CNT_W-1:0] oob_q, oob_d;
  assign oob_count = oob_q;
  always_comb
    oob_d = cfg_acc ? '0 : (s2_v_q && !in_map && oob_q != '1) ? oob_q + 1'b1 : oob_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) oob_q <= '0;
    else oob_q <= oob_d;
`endif
endmodule
